cnt_delta_recover: RTL and testbench
====================================

// Module: cnt_delta_recover
// PURPOSE
//  Receive-side inverse of the accumulating counter: takes successive counter samples and
//  recovers the per-step increment, delta = cnt[n] - cnt[n-1] mod 2^WIDTH.
//  - Sits downstream of counter outputs on a valid/ready stream.
//  - Passes recovered deltas to checkers and monitors with a 1-entry output register.
//  - Optionally flags steps that differ from an expected increment.
// PARAMETERS
//  WIDTH    4  width of counter samples and of recovered deltas
//  INITVAL  0  reference value used as the "previous" sample after reset/restart
//              (matches the counter's own power-up value)
// PORTS
//  clock      in   1      single clock, all logic on posedge
//  resetn     in   1      synchronous, active-low reset
//  restart    in   1      sync re-prime: next accepted sample is differenced against INITVAL
//  in_valid   in   1      in_cnt holds a counter sample
//  in_ready   out  1      sample accepted when in_valid && in_ready
//  in_cnt     in   WIDTH  counter sample
//  out_valid  out  1      out_delta valid
//  out_ready  in   1      consumer takes out_delta when out_valid && out_ready
//  out_delta  out  WIDTH  recovered increment
//  exp_delta  in   WIDTH  expected increment; port default value 10 when left unconnected
//  err        out  1      sticky step-mismatch flag
//  err_cnt    out  WIDTH  saturating mismatch count
// BEHAVIOUR
//  - Reset (resetn=0 at posedge): out_valid=0, out_delta=0, err=0, err_cnt=0,
//    prev=INITVAL, state=UNPRIMED.
//  - in_ready = !out_valid || out_ready (combinational). Full-throughput pipeline.
//  - Accept (in_valid && in_ready):
//    - out_delta <= in_cnt - prev, truncated to WIDTH (wrap-around is a normal
//      result: 4'h1 - 4'hF = 4'h2).
//    - prev <= in_cnt; out_valid <= 1; state <= PRIMED.
//    - Latency: 1 cycle from accept to out_valid.
//  - Drain only (out_valid && out_ready, no accept): out_valid <= 0; out_delta holds its value.
//  - Stall (out_valid && !out_ready): out_delta/out_valid stable; in_ready=0; input is not
//    consumed; producer must hold in_cnt.
//  - Simultaneous drain and accept: new delta replaces old in the same edge; no bubble.
//  - States:
//    - UNPRIMED: first accepted sample differences against INITVAL, then -> PRIMED.
//    - PRIMED: differences against prev.
//  - restart=1 at posedge:
//    - prev <= INITVAL; state <= UNPRIMED.
//    - If an accept occurs on the same edge, the sample is differenced against INITVAL,
//      prev <= in_cnt, state <= PRIMED.
//    - The output register is not touched (pending delta still delivered).
//  - Reset mid-stream: a pending out_delta is discarded; no handshake is completed.
// CONFIGURATION
//  - STEP_CHECK_EN defined: on each accept in PRIMED state, if computed delta != exp_delta:
//    - err <= 1 (sticky until reset);
//    - err_cnt <= err_cnt + 1, saturating at 2^WIDTH-1.
//    - The first sample after reset/restart is never checked.
//  - STEP_CHECK_EN undefined: err and err_cnt are constant 0; exp_delta is ignored.
// TESTING
//  1. Reset, out_ready=1, send 1,3,5,7 (INITVAL=0) -> deltas 1,2,2,2; out_valid 1 cycle after each accept.
//  2. Send 4'hE, 4'h1 -> deltas 4'hE, 4'h3 (wrap). Then hold out_ready=0 for 3 cycles
//     with in_valid=1 -> in_ready=0, out_delta stable, no sample lost when released.
//  3. Back-to-back accepts with out_ready=1 every cycle, 8 samples -> 8 deltas, zero bubbles.
//  4. After prev=9, assert restart together with sample 5 -> delta 5 (vs INITVAL), next sample 6 -> delta 1.
//  5. STEP_CHECK_EN, exp_delta unconnected (10): send 0,10,4,5 -> deltas 0,10,10,1; err=1, err_cnt=1.
//     Then 20 further bad steps -> err_cnt saturates at 15.
//  6. Assert resetn=0 while out_valid=1 and out_ready=0 -> next cycle out_valid=0, err=0;
//     next sample is differenced against INITVAL.

Source files
------------

// File: rtl/cnt_delta_recover.sv
// Recovers per-step increments from successive counter samples on a valid/ready stream.
// Optional step checking against exp_delta is enabled by defining STEP_CHECK_EN.
module cnt_delta_recover #(
    parameter int               WIDTH   = 4,
    parameter logic [WIDTH-1:0] INITVAL = '0
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             restart,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_cnt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_delta,
    input  logic [WIDTH-1:0] exp_delta = WIDTH'(10),
    output logic             err,
    output logic [WIDTH-1:0] err_cnt
);

    typedef enum logic {
        UNPRIMED = 1'b0,
        PRIMED   = 1'b1
    } state_t;

    function automatic logic [WIDTH-1:0] sat_inc(input logic [WIDTH-1:0] v);
        return (v == {WIDTH{1'b1}}) ? v : v + WIDTH'(1);
    endfunction

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_prev;
    logic [WIDTH-1:0] r_delta_p1;
    logic             r_vld_p1;
    logic             w_accept;
    logic             w_first;
    logic [WIDTH-1:0] w_ref;
    logic [WIDTH-1:0] w_delta;

    assign in_ready  = !r_vld_p1 || out_ready;
    assign w_accept  = in_valid && in_ready;
    assign out_valid = r_vld_p1;
    assign out_delta = r_delta_p1;

    // A restart on the accepting edge makes this sample the first one again.
    assign w_first = restart || (r_state == UNPRIMED);
    assign w_ref   = w_first ? INITVAL : r_prev;
    assign w_delta = in_cnt - w_ref;

    always_comb begin
        w_state_nxt = r_state;
        if (w_accept) begin
            w_state_nxt = PRIMED;
        end else if (restart) begin
            w_state_nxt = UNPRIMED;
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_state <= UNPRIMED;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Stage p1: output register, replaced in place on drain+accept so there is no bubble.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_vld_p1   <= 1'b0;
            r_delta_p1 <= '0;
            r_prev     <= INITVAL;
        end else if (w_accept) begin
            r_vld_p1   <= 1'b1;
            r_delta_p1 <= w_delta;
            r_prev     <= in_cnt;
        end else begin
            if (out_ready) begin
                r_vld_p1 <= 1'b0;
            end
            if (restart) begin
                r_prev <= INITVAL;
            end
        end
    end

`ifdef STEP_CHECK_EN
    logic             r_err;
    logic [WIDTH-1:0] r_err_cnt;
    logic             w_step_bad;

    assign w_step_bad = w_accept && !w_first && (w_delta != exp_delta);

    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_err     <= 1'b0;
            r_err_cnt <= '0;
        end else if (w_step_bad) begin
            r_err     <= 1'b1;
            r_err_cnt <= sat_inc(r_err_cnt);
        end
    end

    assign err     = r_err;
    assign err_cnt = r_err_cnt;
`else
    logic w_unused_exp;

    assign w_unused_exp = ^{exp_delta, sat_inc('0)};
    assign err          = 1'b0;
    assign err_cnt      = '0;
`endif

endmodule

// File: tb/tb_cnt_delta_recover.sv
// Directed bench for cnt_delta_recover: a reference model pushes expected deltas into a
// scoreboard queue on accept; they are popped and compared when the output handshakes.
module tb_cnt_delta_recover;

    localparam int         WIDTH = 4;
    localparam logic [3:0] INIT  = 4'h0;

    logic             clock = 1'b0;
    logic             resetn = 1'b0;
    logic             restart = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_cnt = '0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [WIDTH-1:0] out_delta;
    logic [WIDTH-1:0] exp_d = 4'd10;
    logic             err;
    logic [WIDTH-1:0] err_cnt;

    int errors = 0;
    int checks = 0;

    logic [3:0] sb[$];
    logic       m_ovalid  = 1'b0;
    logic       m_primed  = 1'b0;
    logic [3:0] m_prev    = INIT;
    logic       m_err     = 1'b0;
    logic [3:0] m_err_cnt = 4'h0;

    cnt_delta_recover #(.WIDTH(WIDTH), .INITVAL(INIT)) dut (
        .clock     (clock),
        .resetn    (resetn),
        .restart   (restart),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_cnt    (in_cnt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_delta (out_delta),
        .exp_delta (exp_d),
        .err       (err),
        .err_cnt   (err_cnt)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, want);
        end
    endtask

    // One clock: check outputs against the model before the edge, advance the model, clock.
    task automatic cycle();
        logic       acc;
        logic [3:0] ref_v;
        logic [3:0] d;
        logic [3:0] want;
        #1;
        chk("out_valid", out_valid, m_ovalid);
        chk("in_ready", in_ready, !m_ovalid || out_ready);
        chk("err", err, m_err);
        chk("err_cnt", err_cnt, m_err_cnt);
        acc = in_valid && (!m_ovalid || out_ready);
        if (m_ovalid && out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL sb_underflow: observed=%0h expected=none", out_delta);
            end else begin
                want = sb.pop_front();
                chk("out_delta", out_delta, want);
            end
        end
        if (acc) begin
            ref_v = (restart || !m_primed) ? INIT : m_prev;
            d = in_cnt - ref_v;
            sb.push_back(d);
`ifdef STEP_CHECK_EN
            if (m_primed && !restart && d != exp_d) begin
                m_err = 1'b1;
                if (m_err_cnt != 4'hF) m_err_cnt = m_err_cnt + 4'h1;
            end
`endif
            m_prev   = in_cnt;
            m_primed = 1'b1;
            m_ovalid = 1'b1;
        end else begin
            if (out_ready) m_ovalid = 1'b0;
            if (restart) begin
                m_prev   = INIT;
                m_primed = 1'b0;
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic send(input logic [3:0] v);
        in_valid = 1'b1;
        in_cnt   = v;
        cycle();
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        @(posedge clock);
        #1;
        resetn    = 1'b1;
        m_ovalid  = 1'b0;
        m_primed  = 1'b0;
        m_prev    = INIT;
        m_err     = 1'b0;
        m_err_cnt = 4'h0;
        sb.delete();
    endtask

    initial begin
        @(posedge clock);
        do_reset();
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_delta", out_delta, 4'h0);
        chk("rst_err", err, 1'b0);
        chk("rst_err_cnt", err_cnt, 4'h0);

        // 1: basic deltas with one-cycle latency
        send(4'd1);
        in_valid = 1'b0;
        #1;
        chk("lat_valid", out_valid, 1'b1);
        chk("lat_delta", out_delta, 4'd1);
        send(4'd3);
        send(4'd5);
        send(4'd7);
        idle(1);
        chk("t1_last", out_delta, 4'd2);

        // 2: restart without accept, wrap-around, then stall
        restart = 1'b1;
        idle(1);
        restart = 1'b0;
        send(4'hE);
        send(4'h1);
        in_valid = 1'b0;
        #1;
        chk("wrap_delta", out_delta, 4'h3);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_cnt    = 4'h4;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("stall_delta", out_delta, 4'h3);
            chk("stall_ready", in_ready, 1'b0);
        end
        out_ready = 1'b1;
        cycle();
        idle(1);

        // 3: eight back-to-back samples, no bubbles
        for (int i = 0; i < 8; i++) send(4'(3 * i + 2));
        idle(1);

        // 4: restart on the accepting edge
        send(4'd9);
        restart = 1'b1;
        send(4'd5);
        restart = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("restart_delta", out_delta, 4'd5);
        send(4'd6);
        idle(1);
        chk("post_restart", out_delta, 4'd1);

        // 5: step checking against exp_delta = 10, then saturation
        do_reset();
        send(4'd0);
        send(4'd10);
        send(4'd4);
        send(4'd5);
        idle(1);
        for (int i = 0; i < 20; i++) send(4'd5);
        idle(1);
`ifdef STEP_CHECK_EN
        chk("err_final", err, 1'b1);
        chk("err_cnt_sat", err_cnt, 4'hF);
`else
        chk("err_off", err, 1'b0);
        chk("err_cnt_off", err_cnt, 4'h0);
`endif

        // 6: reset while a delta is pending and stalled
        out_ready = 1'b0;
        send(4'd8);
        in_valid = 1'b0;
        #1;
        chk("pend_valid", out_valid, 1'b1);
        out_ready = 1'b1;
        do_reset();
        chk("mid_rst_valid", out_valid, 1'b0);
        chk("mid_rst_err", err, 1'b0);
        chk("mid_rst_delta", out_delta, 4'h0);
        send(4'd3);
        idle(1);
        chk("after_rst", out_delta, 4'd3);

        idle(2);
        chk("sb_empty", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
